// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use hazard control for a 5-stage pipeline.
// Selects are decided in ID and registered for EX; stall/bubble are combinational.
module fwd_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic             branch_taken,
    output logic [1:0]       src1,
    output logic [1:0]       src2,
    output logic             stall,
    output logic             bubble,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [1:0]       src1_q, src1_d;
    logic [1:0]       src2_q, src2_d;
    logic [4:0]       mem_rd_q, mem_rd_d;
    logic             mem_rw_q, mem_rw_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
    logic load_use;
    logic [1:0] sel_rs, sel_rt;

    always_comb begin
        ex_hit_rs  = ex_reg_write && (ex_rd == id_rs) && (id_rs != 5'd0);
        ex_hit_rt  = ex_reg_write && (ex_rd == id_rt) && (id_rt != 5'd0);
        mem_hit_rs = mem_rw_q && (mem_rd_q == id_rs) && (id_rs != 5'd0);
        mem_hit_rt = mem_rw_q && (mem_rd_q == id_rt) && (id_rt != 5'd0);

        // The EX producer is younger than the MEM one, so it is checked first.
        sel_rs = 2'b00;
        if (ex_hit_rs)
            sel_rs = 2'b01;
        else if (mem_hit_rs)
            sel_rs = 2'b10;

        sel_rt = 2'b00;
        if (id_uses_rt) begin
            if (ex_hit_rt)
                sel_rt = 2'b01;
            else if (mem_hit_rt)
                sel_rt = 2'b10;
        end

        load_use = ex_mem_read && (ex_hit_rs || (id_uses_rt && ex_hit_rt));
        stall    = load_use && !branch_taken && !rst;
        bubble   = (load_use || branch_taken) && !rst;
    end

    always_comb begin
        src1_d      = bubble ? 2'b00 : sel_rs;
        src2_d      = bubble ? 2'b00 : sel_rt;
        mem_rd_d    = ex_rd;
        mem_rw_d    = ex_reg_write;
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src1_q      <= 2'b00;
            src2_q      <= 2'b00;
            mem_rd_q    <= 5'd0;
            mem_rw_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            mem_rd_q    <= mem_rd_d;
            mem_rw_q    <= mem_rw_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign src1      = src1_q;
    assign src2      = src2_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed scenarios plus random traffic checked
// against a producer-history reference model.
module tb_fwd_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rd;
    logic        id_uses_rt, ex_reg_write, ex_mem_read, branch_taken;
    logic [1:0]  src1, src2, src1_b, src2_b;
    logic        stall, bubble, stall_b, bubble_b;
    logic [15:0] stall_cnt;
    logic [3:0]  stall_cnt_b;

    fwd_hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .branch_taken(branch_taken), .src1(src1), .src2(src2), .stall(stall),
        .bubble(bubble), .stall_cnt(stall_cnt)
    );

    fwd_hazard_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .branch_taken(branch_taken), .src1(src1_b), .src2(src2_b), .stall(stall_b),
        .bubble(bubble_b), .stall_cnt(stall_cnt_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // Reference model: producers listed newest first (index 0 = EX, 1 = MEM).
    logic [4:0] prod_rd [2];
    bit         prod_rw [2];
    int         exp_src1, exp_src2, exp_cnt16, exp_cnt4;
    bit         model_valid = 0;

    function automatic int pick(input logic [4:0] r);
        if (r == 0) return 0;
        for (int age = 0; age < 2; age++)
            if (prod_rw[age] && prod_rd[age] == r) return age + 1;
        return 0;
    endfunction

    task automatic cycle(input bit r, input logic [4:0] rs, input logic [4:0] rt,
                         input bit urt, input logic [4:0] erd, input bit erw,
                         input bit emr, input bit br);
        bit lu, e_stall, e_bubble;
        rst = r; id_rs = rs; id_rt = rt; id_uses_rt = urt;
        ex_rd = erd; ex_reg_write = erw; ex_mem_read = emr; branch_taken = br;
        prod_rd[0] = erd;
        prod_rw[0] = erw;
        #4;
        lu = emr && ((pick(rs) == 1) || (urt && pick(rt) == 1));
        e_stall  = !r && lu && !br;
        e_bubble = !r && (lu || br);
        chk("stall", stall, e_stall);
        chk("bubble", bubble, e_bubble);
        chk("stall_b", stall_b, e_stall);
        if (model_valid) begin
            chk("src1", src1, exp_src1);
            chk("src2", src2, exp_src2);
            chk("cnt16", stall_cnt, exp_cnt16);
            chk("cnt4", stall_cnt_b, exp_cnt4);
        end
        @(posedge clk);
        if (r) begin
            exp_src1 = 0; exp_src2 = 0; exp_cnt16 = 0; exp_cnt4 = 0;
            prod_rd[1] = 0; prod_rw[1] = 0;
            model_valid = 1;
        end else begin
            exp_src1 = e_bubble ? 0 : pick(rs);
            exp_src2 = (e_bubble || !urt) ? 0 : pick(rt);
            if (e_stall) begin
                if (exp_cnt16 < 65535) exp_cnt16++;
                if (exp_cnt4 < 15) exp_cnt4++;
            end
            prod_rd[1] = erd; prod_rw[1] = erw;
        end
        $display("cyc rst=%0d rs=%0d rt=%0d urt=%0d exrd=%0d exrw=%0d exmr=%0d br=%0d -> stall=%0d bubble=%0d",
                 r, rs, rt, urt, erd, erw, emr, br, e_stall, e_bubble);
        #1;
    endtask

    initial begin
        rst = 1'b1; id_rs = 0; id_rt = 0; id_uses_rt = 0;
        ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0; branch_taken = 0;
        prod_rd[1] = 0; prod_rw[1] = 0;
        @(posedge clk);
        #1;

        // Reset with an active EX hit
        cycle(1, 5, 0, 0, 5, 1, 0, 0);
        cycle(1, 5, 0, 0, 5, 1, 0, 0);
        chk("rst_src1", src1, 0);
        chk("rst_cnt", stall_cnt, 0);

        // EX forwarding on both operands
        cycle(0, 3, 3, 1, 3, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);

        // MEM forwarding and newest-wins priority
        cycle(0, 0, 0, 0, 4, 1, 0, 0);
        cycle(0, 4, 7, 1, 7, 1, 0, 0);
        chk("mem_src1", src1, 2);
        chk("ex_src2", src2, 1);
        cycle(0, 0, 0, 0, 4, 1, 0, 0);
        cycle(0, 4, 0, 0, 4, 1, 0, 0);
        chk("newest_src1", src1, 1);

        // Load-use stall, then resolution from MEM
        cycle(0, 8, 0, 0, 8, 1, 1, 0);
        chk("lu_src1", src1, 0);
        chk("lu_cnt", stall_cnt, 1);
        cycle(0, 8, 0, 0, 0, 0, 0, 0);
        chk("after_src1", src1, 2);

        // Flush dominates load-use; rt load with id_uses_rt=0
        cycle(0, 9, 0, 0, 9, 1, 1, 1);
        cycle(0, 0, 6, 0, 6, 1, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);

        // Register zero
        cycle(0, 0, 0, 1, 0, 1, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        chk("r0_src1", src1, 0);

        // Counter saturation on the 4-bit instance
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++)
            cycle(0, 8, 0, 0, 8, 1, 1, 0);
        chk("sat_cnt4", stall_cnt_b, 15);
        chk("cnt16_20", stall_cnt, 20);

        // Reset in a stall cycle cancels it and clears the shadow
        cycle(1, 8, 0, 0, 8, 1, 1, 0);
        cycle(0, 8, 0, 0, 0, 0, 0, 0);
        chk("post_rst_src1", src1, 0);

        // Random traffic over a small register range to provoke hits
        for (int i = 0; i < 600; i++)
            cycle(($urandom_range(0, 49) == 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Forwarding and hazard control unit for the 5-stage pipeline. It produces the per-operand forwarding selects that the EX stage consumes. It also produces the load-use stall and bubble controls for the front end. Forwarding decisions are made while an instruction is in ID, registered, and presented in the cycle that instruction occupies EX. The unit keeps its own shadow of the MEM-stage destination register.

## Interface

Parameters:
- `CNT_W`, default 16: width of the saturating stall-event counter.

Ports:
- `clk`  in  1  single pipeline clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_rs`  in  5  rs field of the instruction in ID.
- `id_rt`  in  5  rt field of the instruction in ID.
- `id_uses_rt`  in  1  ID instruction reads rt as a source (R-type, sw, beq).
- `ex_rd`  in  5  destination register of the instruction in EX, after RegDst selection.
- `ex_reg_write`  in  1  instruction in EX writes the register file.
- `ex_mem_read`  in  1  instruction in EX is a load.
- `branch_taken`  in  1  taken branch resolved this cycle; the ID instruction is discarded.
- `src1`  out  2  operand-A select for EX, registered: 00 register file, 01 EX/MEM result, 10 WB data.
- `src2`  out  2  operand-B select for EX, registered, same encoding as `src1`.
- `stall`  out  1  combinational; holds PC and IF/ID this cycle.
- `bubble`  out  1  combinational; ID/EX loads a NOP this cycle.
- `stall_cnt`  out  CNT_W  saturating count of load-use stall cycles.

## Operation

- **MEM shadow.** Every cycle, unconditionally, `mem_rd <= ex_rd` and `mem_rw <= ex_reg_write`. The EX stage always advances, so a stall inserts its bubble behind the load.
- **Register file.** The register file is write-through: a WB write is visible to an ID read in the same cycle. No forwarding is generated for a producer that is in WB while the consumer is in ID.
- **Match definitions.** For a source register `r`:
  - `ex_hit(r)` is `ex_reg_write` and `ex_rd == r` and `r != 0`.
  - `mem_hit(r)` is `mem_rw` and `mem_rd == r` and `r != 0`.
- **Next select for a source `r`.**
  - If `ex_hit(r)`, select 01, because the producer will be in MEM next cycle.
  - Else if `mem_hit(r)`, select 10, because the producer will be in WB next cycle.
  - Otherwise select 00.
  - The newest producer always wins.
- **Operand B.** `src2` uses `id_rt` only when `id_uses_rt` is 1; otherwise `src2` is 00.
- **Load-use.** `load_use` is `ex_mem_read` and (`ex_hit(id_rs)` or (`id_uses_rt` and `ex_hit(id_rt)`)).
- **Control outputs.**
  - `stall` is `load_use` and not `branch_taken` and not `rst`.
  - `bubble` is `load_use` or `branch_taken`, and not `rst`.
- **Select register update.** When `bubble` is 1, the next `src1` and `src2` are 00, because a NOP enters EX. Otherwise they take the computed selects.
- **After a stall.** The same ID instruction is re-evaluated next cycle. The load is then in MEM shadow, so the select resolves to 10. No second stall occurs unless a new load sits in EX.
- **Flush priority.** `branch_taken` dominates `load_use`. There is no stall (the ID instruction is dead), and there is no `stall_cnt` increment.
- **Stall counter.** `stall_cnt` increments by 1 in each cycle `stall` is 1 and saturates at all-ones.
- **Register 0.** Writes to register 0 are never forwarded and never cause a stall.

## Timing

- **Reset** (synchronous; outputs take these values at the first rising edge with `rst` high):
  - `src1` = 00 and `src2` = 00.
  - `mem_rd` = 0 and `mem_rw` = 0.
  - `stall_cnt` = 0.
- **During reset.** `stall` and `bubble` are forced to 0 combinationally while `rst` is high.
- **Select latency.** `src1`/`src2` are valid exactly one cycle after the ID-stage inputs that produced them. That is the cycle in which the corresponding instruction is in EX.
- **Stall and bubble latency.** `stall` and `bubble` are zero-latency, combinational from the current-cycle inputs plus `mem_rd`/`mem_rw`.
- **Stall length.** A load-use stall lasts exactly one cycle per load producer.
- **Back-to-back loads.** Two consecutive loads feeding one consumer give one stall cycle per load that reaches EX adjacent to the consumer.
- **Reset mid-stall.** Reset during a stall cycle cancels it. `stall_cnt` is cleared, and the shadow is cleared, so the next instruction sees no MEM producer.

## Test plan

- **Reset.** Assert `rst` for 2 cycles with `ex_reg_write`=1, `ex_rd`=5, `id_rs`=5 -> `src1`=00, `src2`=00, `stall`=0, `bubble`=0, `stall_cnt`=0.
- **EX forwarding on both operands.** `ex_rd`=3, `ex_reg_write`=1, `id_rs`=3, `id_rt`=3, `id_uses_rt`=1 -> next cycle `src1`=01 and `src2`=01.
- **MEM forwarding and priority.**
  - Cycle n: `ex_rd`=4 writing.
  - Cycle n+1: `ex_rd`=7 writing, `id_rs`=4, `id_rt`=7.
  - Required: cycle n+2 `src1`=10, `src2`=01.
  - Repeat with both producers targeting register 4 -> `src1`=01.
- **Load-use.**
  - `ex_mem_read`=1, `ex_rd`=8, `id_rs`=8 -> `stall`=1, `bubble`=1 that cycle; next cycle `src1`=00 and `stall_cnt`=1.
  - Cycle after that, with `id_rs`=8 held and `ex_reg_write`=0 -> `stall`=0; following cycle `src1`=10.
- **Flush versus load-use, and `id_uses_rt`.**
  - Load-use condition plus `branch_taken`=1 -> `stall`=0, `bubble`=1, `stall_cnt` unchanged, next `src1`=00.
  - Load targeting `id_rt` with `id_uses_rt`=0 -> no stall.
- **Register zero and counter saturation.**
  - `ex_rd`=0 writing, `id_rs`=0 -> `src1`=00.
  - With `ex_mem_read`=1 and `ex_rd`=0 -> no stall.
  - With `CNT_W`=4, hold load-use for 20 cycles -> `stall_cnt` holds at 15.
